// File: rtl/branch_sched.sv
// Branch resolution sequencer: latches an RV32I branch, drives a shared external
// comparator, then hands back the taken flag and next PC with running statistics.
module branch_sched #(
  parameter int WIDTH_DATA_LENGTH = 32,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [2:0]                   req_funct3,
  input  logic [WIDTH_DATA_LENGTH-1:0] req_rs1,
  input  logic [WIDTH_DATA_LENGTH-1:0] req_rs2,
  input  logic [WIDTH_DATA_LENGTH-1:0] req_pc,
  input  logic [WIDTH_DATA_LENGTH-1:0] req_imm,
  output logic [WIDTH_DATA_LENGTH-1:0] cmp_A,
  output logic [WIDTH_DATA_LENGTH-1:0] cmp_B,
  output logic                         cmp_BrUn,
  input  logic                         cmp_BrEq,
  input  logic                         cmp_BrLT,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_taken,
  output logic [WIDTH_DATA_LENGTH-1:0] rsp_target,
  output logic                         rsp_illegal,
  output logic [CNT_WIDTH-1:0]         br_cnt,
  output logic [CNT_WIDTH-1:0]         taken_cnt
);

  typedef enum logic [1:0] {IDLE, COMPARE, RESULT} stateType;

  stateType                     state;
  logic [2:0]                   funct3Q;
  logic [WIDTH_DATA_LENGTH-1:0] rs1Q, rs2Q, pcQ, immQ;
  logic                         takenQ, illegalQ;
  logic [WIDTH_DATA_LENGTH-1:0] targetQ;
  logic [CNT_WIDTH-1:0]         brCount, takenCount;

  logic                         takenNext, illegalNext;
  logic [WIDTH_DATA_LENGTH-1:0] targetNext;

  // funct3[1] separates the signed (BLT/BGE) and unsigned (BLTU/BGEU) pairs.
  assign cmp_A    = rs1Q;
  assign cmp_B    = rs2Q;
  assign cmp_BrUn = funct3Q[1];

  always_comb begin
    takenNext   = 1'b0;
    illegalNext = 1'b0;
    case (funct3Q)
      3'b000:         takenNext   = cmp_BrEq;
      3'b001:         takenNext   = !cmp_BrEq;
      3'b100, 3'b110: takenNext   = cmp_BrLT;
      3'b101, 3'b111: takenNext   = !cmp_BrLT;
      default:        illegalNext = 1'b1;
    endcase
  end

  assign targetNext = takenNext ? (pcQ + immQ) : (pcQ + WIDTH_DATA_LENGTH'(4));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      funct3Q    <= '0;
      rs1Q       <= '0;
      rs2Q       <= '0;
      pcQ        <= '0;
      immQ       <= '0;
      takenQ     <= 1'b0;
      illegalQ   <= 1'b0;
      targetQ    <= '0;
      brCount    <= '0;
      takenCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            funct3Q <= req_funct3;
            rs1Q    <= req_rs1;
            rs2Q    <= req_rs2;
            pcQ     <= req_pc;
            immQ    <= req_imm;
            state   <= COMPARE;
          end
        end
        COMPARE: begin
          takenQ   <= takenNext;
          illegalQ <= illegalNext;
          targetQ  <= targetNext;
          state    <= RESULT;
        end
        RESULT: begin
          // Statistics only count legal branches, and only once they are consumed.
          if (rsp_ready) begin
            if (!illegalQ) begin
              brCount <= brCount + CNT_WIDTH'(1);
              if (takenQ) takenCount <= takenCount + CNT_WIDTH'(1);
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready   = (state == IDLE);
  assign rsp_valid   = (state == RESULT);
  assign rsp_taken   = takenQ;
  assign rsp_target  = targetQ;
  assign rsp_illegal = illegalQ;
  assign br_cnt      = brCount;
  assign taken_cnt   = takenCount;

endmodule

// File: tb/tb_branch_sched.sv
// Directed bench for branch_sched with a behavioural model of the external comparator;
// counters are narrowed to 4 bits so wrap-around is reachable.
module tb_branch_sched;

  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          reqValid, reqReady;
  logic [2:0]    reqFunct3;
  logic [W-1:0]  reqRs1, reqRs2, reqPc, reqImm;
  logic [W-1:0]  cmpA, cmpB;
  logic          cmpBrUn, cmpBrEq, cmpBrLT;
  logic          rspValid, rspReady, rspTaken, rspIllegal;
  logic [W-1:0]  rspTarget;
  logic [CW-1:0] brCnt, takenCnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Shared comparator as the surrounding pipeline would provide it.
  assign cmpBrEq = (cmpA == cmpB);
  assign cmpBrLT = cmpBrUn ? (cmpA < cmpB) : ($signed(cmpA) < $signed(cmpB));

  branch_sched #(.WIDTH_DATA_LENGTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(reqValid), .req_ready(reqReady), .req_funct3(reqFunct3),
    .req_rs1(reqRs1), .req_rs2(reqRs2), .req_pc(reqPc), .req_imm(reqImm),
    .cmp_A(cmpA), .cmp_B(cmpB), .cmp_BrUn(cmpBrUn),
    .cmp_BrEq(cmpBrEq), .cmp_BrLT(cmpBrLT),
    .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_taken(rspTaken),
    .rsp_target(rspTarget), .rsp_illegal(rspIllegal),
    .br_cnt(brCnt), .taken_cnt(takenCnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  // Issues one request and walks it through COMPARE until rsp_valid rises.
  task automatic applyStimulus(input logic [2:0] f3, input logic [W-1:0] rs1,
                               input logic [W-1:0] rs2, input logic [W-1:0] pc,
                               input logic [W-1:0] imm);
    reqValid = 1'b1; reqFunct3 = f3; reqRs1 = rs1; reqRs2 = rs2; reqPc = pc; reqImm = imm;
    checkOutput("req_ready idle", W'(reqReady), 32'd1);
    tick();
    reqValid = 1'b0;
    checkOutput("rsp_valid compare", W'(rspValid), 32'd0);
    checkOutput("req_ready compare", W'(reqReady), 32'd0);
    checkOutput("cmp_A", cmpA, rs1);
    checkOutput("cmp_B", cmpB, rs2);
    checkOutput("cmp_BrUn", W'(cmpBrUn), W'(f3[1]));
    tick();
    checkOutput("rsp_valid result", W'(rspValid), 32'd1);
  endtask

  task automatic checkResult(input logic taken, input logic [W-1:0] target,
                             input logic illegal);
    checkOutput("rsp_taken", W'(rspTaken), W'(taken));
    checkOutput("rsp_target", rspTarget, target);
    checkOutput("rsp_illegal", W'(rspIllegal), W'(illegal));
  endtask

  task automatic handshake(input logic [CW-1:0] expBr, input logic [CW-1:0] expTaken);
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;
    checkOutput("rsp_valid after hs", W'(rspValid), 32'd0);
    checkOutput("req_ready after hs", W'(reqReady), 32'd1);
    checkOutput("br_cnt", W'(brCnt), W'(expBr));
    checkOutput("taken_cnt", W'(takenCnt), W'(expTaken));
  endtask

  initial begin
    rst = 1'b1; reqValid = 1'b0; rspReady = 1'b0;
    reqFunct3 = '0; reqRs1 = '0; reqRs2 = '0; reqPc = '0; reqImm = '0;
    tick();
    tick();
    checkOutput("reset rsp_valid", W'(rspValid), 32'd0);
    checkOutput("reset rsp_taken", W'(rspTaken), 32'd0);
    checkOutput("reset rsp_illegal", W'(rspIllegal), 32'd0);
    checkOutput("reset rsp_target", rspTarget, 32'd0);
    checkOutput("reset cmp_A", cmpA, 32'd0);
    checkOutput("reset cmp_B", cmpB, 32'd0);
    checkOutput("reset cmp_BrUn", W'(cmpBrUn), 32'd0);
    checkOutput("reset br_cnt", W'(brCnt), 32'd0);
    checkOutput("reset taken_cnt", W'(takenCnt), 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("req_ready after reset", W'(reqReady), 32'd1);

    // BEQ equal operands
    applyStimulus(3'b000, 32'h0000_1234, 32'h0000_1234, 32'h100, 32'h20);
    checkResult(1'b1, 32'h120, 1'b0);
    handshake(4'd1, 4'd1);

    // BLT signed: 0x80000000 is negative
    applyStimulus(3'b100, 32'h8000_0000, 32'h1, 32'h200, 32'h40);
    checkResult(1'b1, 32'h240, 1'b0);
    handshake(4'd2, 4'd2);

    // BLTU not taken, held under backpressure while a new request is offered
    applyStimulus(3'b110, 32'h8000_0000, 32'h1, 32'h300, 32'h40);
    reqValid = 1'b1; reqFunct3 = 3'b000; reqRs1 = 32'hDEAD_BEEF; reqRs2 = 32'h5;
    reqPc = 32'h900; reqImm = 32'h4;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp rsp_valid", W'(rspValid), 32'd1);
      checkOutput("bp req_ready", W'(reqReady), 32'd0);
      checkResult(1'b0, 32'h304, 1'b0);
      checkOutput("bp br_cnt", W'(brCnt), 32'd2);
      tick();
    end
    reqValid = 1'b0;
    handshake(4'd3, 4'd2);
    checkOutput("bp ignored request", cmpA, 32'h8000_0000);

    // BNE taken with negative offset
    applyStimulus(3'b001, 32'h5, 32'h7, 32'h400, 32'hFFFF_FFF0);
    checkResult(1'b1, 32'h3F0, 1'b0);
    handshake(4'd4, 4'd3);

    // BGE signed: -1 >= 1 is false
    applyStimulus(3'b101, 32'hFFFF_FFFF, 32'h1, 32'h500, 32'h8);
    checkResult(1'b0, 32'h504, 1'b0);
    handshake(4'd5, 4'd3);

    // BGEU unsigned: 0xFFFFFFFF >= 1 is true
    applyStimulus(3'b111, 32'hFFFF_FFFF, 32'h1, 32'h600, 32'h8);
    checkResult(1'b1, 32'h608, 1'b0);
    handshake(4'd6, 4'd4);

    // Illegal encodings leave counters alone
    applyStimulus(3'b010, 32'h9, 32'h9, 32'h700, 32'h10);
    checkResult(1'b0, 32'h704, 1'b1);
    handshake(4'd6, 4'd4);
    applyStimulus(3'b011, 32'h1, 32'h2, 32'h800, 32'h10);
    checkResult(1'b0, 32'h804, 1'b1);
    handshake(4'd6, 4'd4);

    // Reset while a response is pending
    applyStimulus(3'b000, 32'h1, 32'h1, 32'hA00, 32'h10);
    rst = 1'b1;
    rspReady = 1'b1;
    tick();
    rst = 1'b0;
    rspReady = 1'b0;
    checkOutput("midrst rsp_valid", W'(rspValid), 32'd0);
    checkOutput("midrst br_cnt", W'(brCnt), 32'd0);
    checkOutput("midrst taken_cnt", W'(takenCnt), 32'd0);
    checkOutput("midrst req_ready", W'(reqReady), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("midrst no stale rsp", W'(rspValid), 32'd0);
    end

    // Counter wrap after 16 taken branches
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(3'b000, 32'h42, 32'h42, 32'h1000, 32'h8);
      checkResult(1'b1, 32'h1008, 1'b0);
      handshake(CW'(i), CW'(i));
    end
    checkOutput("wrap br_cnt", W'(brCnt), 32'd0);
    checkOutput("wrap taken_cnt", W'(takenCnt), 32'd0);

    // pc+4 wraps modulo 2^32
    applyStimulus(3'b001, 32'h3, 32'h3, 32'hFFFF_FFFC, 32'h100);
    checkResult(1'b0, 32'h0000_0000, 1'b0);
    handshake(4'd1, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_sched.md
BRANCH_SCHED -- requirements
Module: branch_sched

Interface
REQ-001 Parameter: WIDTH_DATA_LENGTH, default 32, operand/PC data width.
REQ-002 Parameter: CNT_WIDTH, default 16, statistics counter width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Ports SHALL be, in order:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  branch request present
- req_ready  out  1  block can accept a request
- req_funct3  in  3  RV32I branch funct3
- req_rs1  in  W  first operand
- req_rs2  in  W  second operand
- req_pc  in  W  branch instruction PC
- req_imm  in  W  sign-extended B-type offset
- cmp_A  out  W  comparator operand A
- cmp_B  out  W  comparator operand B
- cmp_BrUn  out  1  comparator unsigned select
- cmp_BrEq  in  1  comparator equal result
- cmp_BrLT  in  1  comparator less-than result
- rsp_valid  out  1  resolution available
- rsp_ready  in  1  consumer accepts resolution
- rsp_taken  out  1  branch taken
- rsp_target  out  W  next PC
- rsp_illegal  out  1  funct3 not a branch encoding
- br_cnt  out  CNT_WIDTH  legal branches resolved
- taken_cnt  out  CNT_WIDTH  taken branches resolved

Function
REQ-005 The block SHALL sequence a shared external combinational comparator through FSM states IDLE, COMPARE, RESULT.
REQ-006 IDLE: req_ready=1; on req_valid=1, the block SHALL latch funct3, rs1, rs2, pc, imm and go to COMPARE.
REQ-007 req_ready SHALL be 0 in COMPARE and RESULT; req_valid is ignored there.
REQ-008 cmp_A/cmp_B SHALL be driven from latched rs1/rs2 at all times; cmp_BrUn SHALL equal latched funct3[1].
REQ-009 COMPARE lasts exactly one cycle; at its closing edge the block SHALL register the outcome and go to RESULT.
REQ-010 Outcome by funct3: 000 taken=BrEq; 001 taken=!BrEq; 100/110 taken=BrLT; 101/111 taken=!BrLT; 010/011 taken=0 with rsp_illegal=1.
REQ-011 rsp_target SHALL be pc+imm when taken, else pc+4, truncated modulo 2^W.
REQ-012 RESULT: rsp_valid=1; rsp_taken, rsp_target, rsp_illegal SHALL hold stable until rsp_ready=1.
REQ-013 On rsp_valid && rsp_ready the block SHALL return to IDLE; latency from accept edge to rsp_valid high is 2 cycles; minimum request spacing is 3 cycles.
REQ-014 On each response handshake with rsp_illegal=0, br_cnt SHALL increment by 1, and taken_cnt SHALL increment by 1 if rsp_taken=1.
REQ-015 Counters SHALL wrap from all-ones to 0; illegal responses SHALL not change either counter.
REQ-016 rsp_valid=0 outside RESULT; rsp_taken/rsp_target/rsp_illegal are don't-care there.

Reset
REQ-017 rst=1 at a clock edge SHALL force IDLE, rsp_valid=0, rsp_taken=0, rsp_illegal=0, rsp_target=0, latched operands/funct3=0 (so cmp_A=cmp_B=0, cmp_BrUn=0), br_cnt=0, taken_cnt=0.
REQ-018 Reset in COMPARE or RESULT SHALL discard the pending branch without a response; reset has priority over all handshakes.
REQ-019 req_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-020 BEQ: funct3=000, rs1=rs2=0x0000_1234, pc=0x100, imm=0x20, comparator model BrEq=1 -> rsp_valid 2 cycles after accept, taken=1, target=0x120, br_cnt=1, taken_cnt=1.
REQ-021 Signed vs unsigned: rs1=0x8000_0000, rs2=0x1; BLT (100) -> cmp_BrUn=0, taken=1; BLTU (110) -> cmp_BrUn=1, taken=0, target=pc+4.
REQ-022 Backpressure: rsp_ready=0 for 5 cycles in RESULT -> outputs stable, req_ready=0, new req_valid ignored; counters update only on the handshake cycle.
REQ-023 Illegal: funct3=010 -> rsp_illegal=1, taken=0, target=pc+4, counters unchanged.
REQ-024 Reset mid-op: rst asserted in RESULT -> next cycle rsp_valid=0, counters=0, req_ready=1; no stale response afterward.
REQ-025 Wrap: CNT_WIDTH=4, 16 taken BEQ handshakes -> br_cnt=0, taken_cnt=0; pc=0xFFFF_FFFC, not taken -> target=0x0000_0000.
